// File: rtl/ex_trap_ctrl_pkg.sv
// Shared types and constants for the external-trap controller.
package ex_trap_ctrl_pkg;

    // Trap id width toward the core; narrower source counts are zero-extended.
    localparam int unsigned EX_TRAP_ID_W = 5;

    // Handshake state: idle, offering a trap, trap accepted and in flight.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StOffer  = 2'd1,
        StActive = 2'd2
    } ex_trap_state_e;

endpackage

// File: rtl/ex_trap_prio_enc.sv
// Lowest-index-first priority encoder for the pending/enabled request vector.
module ex_trap_prio_enc
    import ex_trap_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC = 32
) (
    input  logic [NUM_SRC-1:0]      i_req,
    output logic [EX_TRAP_ID_W-1:0] o_id,
    output logic                    o_any
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_id  = '0;
        o_any = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_id  = EX_TRAP_ID_W'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_trap_ctrl.sv
// External-interrupt controller: synchronises IRQ lines, latches pending requests and
// offers the lowest enabled one to the core, one trap in flight at a time.
// Optional completion timeout enabled by defining EX_TRAP_TIMEOUT_EN.
module ex_trap_ctrl
    import ex_trap_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 32,
    parameter logic [31:0] EDGE_MASK   = 32'hFFFF_FFFF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC-1:0]      irq_src_i,
    input  logic [NUM_SRC-1:0]      irq_en_i,
    output logic                    core_ex_trap_valid_o,
    output logic [EX_TRAP_ID_W-1:0] core_ex_trap_id_o,
    input  logic                    core_ex_trap_ready_i,
    input  logic                    core_ex_trap_cplet_i,
    input  logic [EX_TRAP_ID_W-1:0] core_ex_trap_cplet_id_i,
    output logic [NUM_SRC-1:0]      pending_o,
    output logic                    busy_o
`ifdef EX_TRAP_TIMEOUT_EN
    ,
    output logic                    timeout_err_o
`endif
);

    // Elaboration-time parameter sanity checks.
    if (NUM_SRC == 0 || NUM_SRC > 32) begin : g_bad_num_src
        $error("ex_trap_ctrl: NUM_SRC must be 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("ex_trap_ctrl: SYNC_STAGES must be >= 2");
    end
    if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("ex_trap_ctrl: TIMEOUT_CYC must be 1..65535");
    end

    logic [NUM_SRC-1:0]      r_sync [SYNC_STAGES];
    logic [NUM_SRC-1:0]      r_sync_prev;
    logic [NUM_SRC-1:0]      r_pend_edge;
    logic [NUM_SRC-1:0]      w_pend_edge_d;
    logic [NUM_SRC-1:0]      w_sync;
    logic [NUM_SRC-1:0]      w_rise;
    logic [NUM_SRC-1:0]      w_clr;
    logic [NUM_SRC-1:0]      w_pend;
    ex_trap_state_e          r_state;
    ex_trap_state_e          w_state_d;
    logic [EX_TRAP_ID_W-1:0] r_id;
    logic [EX_TRAP_ID_W-1:0] w_id_d;
    logic [EX_TRAP_ID_W-1:0] w_enc_id;
    logic                    w_enc_any;
    logic                    w_accept;
    logic                    w_cplet_hit;
    logic                    w_timeout;

    assign w_sync      = r_sync[SYNC_STAGES-1];
    assign w_rise      = w_sync & ~r_sync_prev;
    assign w_accept    = (r_state == StOffer) && core_ex_trap_ready_i;
    assign w_cplet_hit = (r_state == StActive) && core_ex_trap_cplet_i &&
                         (core_ex_trap_cplet_id_i == r_id);

    // Synchroniser chain plus one extra stage for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                r_sync[s] <= '0;
            end
            r_sync_prev <= '0;
        end else begin
            r_sync[0] <= irq_src_i;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_sync_prev <= w_sync;
        end
    end

    // Pending next state: edge bits set on rise, cleared on accept (set wins);
    // level bits simply follow the synchronised line.
    always_comb begin
        w_clr         = '0;
        w_pend_edge_d = '0;
        w_pend        = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            w_clr[i] = w_accept && (r_id == EX_TRAP_ID_W'(i));
            if (EDGE_MASK[i]) begin
                w_pend_edge_d[i] = w_rise[i] | (r_pend_edge[i] & ~w_clr[i]);
                w_pend[i]        = r_pend_edge[i];
            end else begin
                w_pend[i]        = w_sync[i];
            end
        end
    end

    // Latched pending bits for edge-triggered sources.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_edge <= '0;
        end else begin
            r_pend_edge <= w_pend_edge_d;
        end
    end

    ex_trap_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .i_req (w_pend & irq_en_i),
        .o_id  (w_enc_id),
        .o_any (w_enc_any)
    );

    // Handshake FSM next state; the id is captured once and held for the whole trap.
    always_comb begin
        w_state_d = r_state;
        w_id_d    = r_id;
        unique case (r_state)
            StIdle: begin
                if (w_enc_any) begin
                    w_id_d    = w_enc_id;
                    w_state_d = StOffer;
                end
            end
            StOffer: begin
                if (core_ex_trap_ready_i) begin
                    w_state_d = StActive;
                end
            end
            StActive: begin
                if (w_cplet_hit || w_timeout) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // FSM state and offered-id registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_id    <= '0;
        end else begin
            r_state <= w_state_d;
            r_id    <= w_id_d;
        end
    end

`ifdef EX_TRAP_TIMEOUT_EN
    localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_CYC);

    logic [15:0] r_to_cnt;
    logic        r_to_err;

    // Leave ACTIVE after exactly TIMEOUT_CYC cycles without a matching completion.
    assign w_timeout = (r_state == StActive) && ((r_to_cnt + 16'd1) == TimeoutLim);

    // Cycles spent in ACTIVE; restarts on every accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_accept) begin
            r_to_cnt <= '0;
        end else if (r_state == StActive) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_err <= 1'b0;
        end else if (w_timeout && !w_cplet_hit) begin
            r_to_err <= 1'b1;
        end
    end

    assign timeout_err_o = r_to_err;
`else
    assign w_timeout = 1'b0;
`endif

    assign core_ex_trap_valid_o = (r_state == StOffer);
    assign core_ex_trap_id_o    = r_id;
    assign pending_o            = w_pend;
    assign busy_o               = (r_state != StIdle);

endmodule
